// File: rtl/countdown_timer_ctrl_pkg.sv
// Shared constants for the countdown timer: state encoding, BCD digit width
// and the per-digit rollover limit used by both set-mode increment and run-mode borrow.
package timer_pkg;

    localparam int BCD_W = 4;

    localparam logic [1:0] ST_SET   = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_PAUSE = 2'b10;
    localparam logic [1:0] ST_ALARM = 2'b11;

    // In mm:ss layout the tens-of-seconds and tens-of-minutes digits stop at 5.
    function automatic logic [BCD_W-1:0] digit_limit(input int i, input bit mmss);
        return (mmss && (i == 1 || i == 3)) ? 4'd5 : 4'd9;
    endfunction

endpackage

// File: rtl/countdown_timer_ctrl_if.sv
// Control/display bundle between the timer core and its surroundings.
// Button and TICK inputs are single-cycle pulses: each cycle they are high counts
// as exactly one event, there is no ready/backpressure, and any pulse the core
// cannot act on in that cycle is simply dropped. Outputs are level signals.
interface countdown_timer_ctrl_if #(parameter int DIGITS = 4);

    logic                  TICK;
    logic                  BLINK;
    logic                  BTN_START_STOP;
    logic                  BTN_SEL;
    logic                  BTN_INC;
    logic [4*DIGITS-1:0]   Q;
    logic [DIGITS-1:0]     E;
    logic [1:0]            STATE;
    logic                  ALARM;

    modport master (
        output TICK, BLINK, BTN_START_STOP, BTN_SEL, BTN_INC,
        input  Q, E, STATE, ALARM
    );

    modport slave (
        input  TICK, BLINK, BTN_START_STOP, BTN_SEL, BTN_INC,
        output Q, E, STATE, ALARM
    );

endinterface

// File: rtl/countdown_timer_ctrl_bcd_digit_down.sv
// One BCD digit of the timer: loadable, wraps on increment without carry, and
// decrements only when every lower digit is zero (borrow_i), reloading to its limit.
module bcd_digit_down
    import timer_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ce_i,
    input  logic             load_i,
    input  logic [BCD_W-1:0] load_val_i,
    input  logic             inc_i,
    input  logic             dec_i,
    input  logic             borrow_i,
    input  logic [BCD_W-1:0] limit_i,
    output logic [BCD_W-1:0] digit_o,
    output logic             borrow_o
);

    logic [BCD_W-1:0] digit_q;
    logic [BCD_W-1:0] digit_d;

    always_comb begin
        digit_d = digit_q;
        if (load_i) begin
            digit_d = load_val_i;
        end else if (inc_i) begin
            digit_d = (digit_q >= limit_i) ? '0 : digit_q + 1'b1;
        end else if (dec_i && borrow_i) begin
            digit_d = (digit_q == '0) ? limit_i : digit_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            digit_q <= '0;
        end else if (ce_i) begin
            digit_q <= digit_d;
        end
    end

    assign digit_o  = digit_q;
    assign borrow_o = (digit_q == '0) && borrow_i;

endmodule

// File: rtl/countdown_timer_ctrl.sv
// Countdown timer core: BCD preset entry, tick-driven countdown, pause/resume
// and a timed alarm phase, driving BCD digits and enables to the display.
module countdown_timer_ctrl
    import timer_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int MMSS_MODE   = 1,
    parameter int ALARM_TICKS = 10
) (
    input  logic                    CLK,
    input  logic                    CLR,
    input  logic                    CE,
    countdown_timer_ctrl_if.slave   bus
);

    localparam int SEL_W = $clog2(DIGITS);
    localparam int QW    = BCD_W * DIGITS;
    localparam logic [QW-1:0] Q_ONE = QW'(1);

    logic [1:0]       state_q, state_d;
    logic [QW-1:0]    preset_q, preset_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [7:0]       alarm_cnt_q, alarm_cnt_d;

    logic [QW-1:0]     q;
    logic [DIGITS-1:0] borrow_out;
    logic              load;
    logic              inc_any;
    logic              dec;
    logic              q_is_zero;
    logic              dec_hits_zero;

    // The top digit's borrow-out is high exactly when every digit is zero.
    assign q_is_zero     = borrow_out[DIGITS-1];
    assign dec_hits_zero = (q == Q_ONE);

    always_comb begin
        state_d     = state_q;
        preset_d    = preset_q;
        sel_d       = sel_q;
        alarm_cnt_d = alarm_cnt_q;
        load        = 1'b0;
        inc_any     = 1'b0;
        dec         = 1'b0;
        case (state_q)
            ST_SET: begin
                if (bus.BTN_START_STOP) begin
                    if (!q_is_zero) begin
                        preset_d = q;
                        state_d  = ST_RUN;
                    end
                end else if (bus.BTN_SEL) begin
                    sel_d = (sel_q == SEL_W'(DIGITS - 1)) ? '0 : sel_q + 1'b1;
                end else if (bus.BTN_INC) begin
                    inc_any = 1'b1;
                end
            end
            ST_RUN: begin
                dec = bus.TICK;
                // Reaching zero wins over a pause request in the same cycle.
                if (bus.TICK && dec_hits_zero) begin
                    state_d = ST_ALARM;
                end else if (bus.BTN_START_STOP) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (bus.BTN_START_STOP) begin
                    state_d = ST_RUN;
                end else if (bus.BTN_SEL) begin
                    state_d = ST_SET;
                    load    = 1'b1;
                    sel_d   = '0;
                end
            end
            default: begin
                if (bus.BTN_START_STOP) begin
                    state_d     = ST_SET;
                    load        = 1'b1;
                    alarm_cnt_d = '0;
                end else if (bus.TICK) begin
                    if (alarm_cnt_q == 8'(ALARM_TICKS - 1)) begin
                        state_d     = ST_SET;
                        load        = 1'b1;
                        alarm_cnt_d = '0;
                    end else begin
                        alarm_cnt_d = alarm_cnt_q + 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q     <= ST_SET;
            preset_q    <= '0;
            sel_q       <= '0;
            alarm_cnt_q <= '0;
        end else if (CE) begin
            state_q     <= state_d;
            preset_q    <= preset_d;
            sel_q       <= sel_d;
            alarm_cnt_q <= alarm_cnt_d;
        end
    end

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        localparam logic [BCD_W-1:0] LIM = digit_limit(i, MMSS_MODE != 0);
        logic borrow_in;
        if (i == 0) begin : g_first
            assign borrow_in = 1'b1;
        end else begin : g_rest
            assign borrow_in = borrow_out[i-1];
        end
        bcd_digit_down u_digit (
            .clk_i      (CLK),
            .rst_i      (CLR),
            .ce_i       (CE),
            .load_i     (load),
            .load_val_i (preset_q[BCD_W*i +: BCD_W]),
            .inc_i      (inc_any && (sel_q == SEL_W'(i))),
            .dec_i      (dec),
            .borrow_i   (borrow_in),
            .limit_i    (LIM),
            .digit_o    (q[BCD_W*i +: BCD_W]),
            .borrow_o   (borrow_out[i])
        );
    end

    always_comb begin
        bus.E = '1;
        case (state_q)
            ST_SET: begin
                for (int i = 0; i < DIGITS; i++) begin
                    bus.E[i] = (sel_q == SEL_W'(i)) ? bus.BLINK : 1'b1;
                end
            end
            ST_ALARM: bus.E = {DIGITS{bus.BLINK}};
            default:  bus.E = '1;
        endcase
    end

    assign bus.Q     = q;
    assign bus.STATE = state_q;
    assign bus.ALARM = (state_q == ST_ALARM);

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Bench for countdown_timer_ctrl: an mm:ss instance and a plain-decimal instance
// share one stimulus stream and are checked every cycle against a value-level model.
module tb_countdown_timer_ctrl;

    localparam int D  = 4;
    localparam int AT = 10;
    localparam int QW = 4 * D;
    localparam int W  = QW + D + 3;

    logic clk = 1'b0;
    logic clr = 1'b0;
    logic ce = 1'b1;
    logic tick = 1'b0;
    logic blink = 1'b0;
    logic ss = 1'b0;
    logic sl = 1'b0;
    logic inc = 1'b0;

    always #5 clk = ~clk;

    countdown_timer_ctrl_if #(.DIGITS(D)) bus0 ();
    countdown_timer_ctrl_if #(.DIGITS(D)) bus1 ();

    assign bus0.TICK = tick;
    assign bus0.BLINK = blink;
    assign bus0.BTN_START_STOP = ss;
    assign bus0.BTN_SEL = sl;
    assign bus0.BTN_INC = inc;
    assign bus1.TICK = tick;
    assign bus1.BLINK = blink;
    assign bus1.BTN_START_STOP = ss;
    assign bus1.BTN_SEL = sl;
    assign bus1.BTN_INC = inc;

    countdown_timer_ctrl #(.DIGITS(D), .MMSS_MODE(1), .ALARM_TICKS(AT)) dut0 (
        .CLK (clk), .CLR (clr), .CE (ce), .bus (bus0)
    );
    countdown_timer_ctrl #(.DIGITS(D), .MMSS_MODE(0), .ALARM_TICKS(AT)) dut1 (
        .CLK (clk), .CLR (clr), .CE (ce), .bus (bus1)
    );

    // Model: index 0 is the mm:ss instance, index 1 the all-decimal one.
    int m_dig[2][D];
    int m_pre[2][D];
    int m_st[2];
    int m_sel[2];
    int m_cnt[2];

    logic [W-1:0] exp_q0[$];
    logic [W-1:0] exp_q1[$];
    int n_checks = 0;
    int n_pass = 0;
    int n_steps = 0;
    bit blink_hold = 1'b0;

    function automatic int lim(input int k, input int i);
        return (k == 0 && (i == 1 || i == 3)) ? 5 : 9;
    endfunction

    // Displayed value as a plain count in the digits' mixed radix.
    function automatic int to_int(input int k);
        int v = 0;
        for (int i = D - 1; i >= 0; i--) v = v * (lim(k, i) + 1) + m_dig[k][i];
        return v;
    endfunction

    task automatic from_int(input int k, input int v);
        for (int i = 0; i < D; i++) begin
            m_dig[k][i] = v % (lim(k, i) + 1);
            v = v / (lim(k, i) + 1);
        end
    endtask

    task automatic reload(input int k);
        for (int i = 0; i < D; i++) m_dig[k][i] = m_pre[k][i];
    endtask

    task automatic model_step(input int k);
        int v;
        if (clr) begin
            for (int i = 0; i < D; i++) begin
                m_dig[k][i] = 0;
                m_pre[k][i] = 0;
            end
            m_st[k] = 0;
            m_sel[k] = 0;
            m_cnt[k] = 0;
        end else if (ce) begin
            case (m_st[k])
                0: begin
                    if (ss) begin
                        if (to_int(k) != 0) begin
                            for (int i = 0; i < D; i++) m_pre[k][i] = m_dig[k][i];
                            m_st[k] = 1;
                        end
                    end else if (sl) begin
                        m_sel[k] = (m_sel[k] + 1) % D;
                    end else if (inc) begin
                        m_dig[k][m_sel[k]] = (m_dig[k][m_sel[k]] == lim(k, m_sel[k])) ? 0 : m_dig[k][m_sel[k]] + 1;
                    end
                end
                1: begin
                    if (tick) begin
                        v = to_int(k) - 1;
                        from_int(k, v);
                        if (v == 0) m_st[k] = 3;
                    end
                    if (m_st[k] == 1 && ss) m_st[k] = 2;
                end
                2: begin
                    if (ss) begin
                        m_st[k] = 1;
                    end else if (sl) begin
                        m_st[k] = 0;
                        reload(k);
                        m_sel[k] = 0;
                    end
                end
                default: begin
                    if (ss) begin
                        m_st[k] = 0;
                        reload(k);
                        m_cnt[k] = 0;
                    end else if (tick) begin
                        m_cnt[k]++;
                        if (m_cnt[k] == AT) begin
                            m_st[k] = 0;
                            reload(k);
                            m_cnt[k] = 0;
                        end
                    end
                end
            endcase
        end
    endtask

    function automatic logic [W-1:0] exp_vec(input int k);
        logic [QW-1:0] q;
        logic [D-1:0] e;
        for (int i = 0; i < D; i++) begin
            q[4*i +: 4] = 4'(m_dig[k][i]);
            if (m_st[k] == 0) e[i] = (i == m_sel[k]) ? blink : 1'b1;
            else if (m_st[k] == 3) e[i] = blink;
            else e[i] = 1'b1;
        end
        return {q, e, 2'(m_st[k]), (m_st[k] == 3)};
    endfunction

    task automatic step(input bit i_ss, input bit i_sl, input bit i_inc, input bit i_tick,
                        input bit i_ce, input bit i_clr);
        @(negedge clk);
        ss = i_ss;
        sl = i_sl;
        inc = i_inc;
        tick = i_tick;
        ce = i_ce;
        clr = i_clr;
        blink = blink_hold ? 1'b1 : 1'((n_steps / 3) % 2);
        n_steps++;
        for (int k = 0; k < 2; k++) model_step(k);
        exp_q0.push_back(exp_vec(0));
        exp_q1.push_back(exp_vec(1));
    endtask

    task automatic p(input bit i_ss, input bit i_sl, input bit i_inc, input bit i_tick);
        step(i_ss, i_sl, i_inc, i_tick, 1'b1, 1'b0);
    endtask

    task automatic rep(input int n, input bit i_ss, input bit i_sl, input bit i_inc, input bit i_tick);
        for (int i = 0; i < n; i++) begin
            p(i_ss, i_sl, i_inc, i_tick);
            p(0, 0, 0, 0);
        end
    endtask

    task automatic do_reset();
        blink_hold = 1'b1;
        step(0, 0, 0, 0, 1'b1, 1'b1);
        blink_hold = 1'b0;
    endtask

    task automatic check(input int k, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL dut%0d step %0d: got Q=%h E=%b STATE=%b ALARM=%b, expected Q=%h E=%b STATE=%b ALARM=%b",
                     k, n_checks, act[W-1 -: QW], act[D+2:3], act[2:1], act[0],
                     exp[W-1 -: QW], exp[D+2:3], exp[2:1], exp[0]);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q0.size() > 0) check(0, {bus0.Q, bus0.E, bus0.STATE, bus0.ALARM}, exp_q0.pop_front());
        if (exp_q1.size() > 0) check(1, {bus1.Q, bus1.E, bus1.STATE, bus1.ALARM}, exp_q1.pop_front());
    end

    initial begin
        // Reset, then START_STOP with Q=0 must stay in SET.
        do_reset();
        p(1, 0, 0, 0);
        p(0, 0, 0, 0);
        // Set 3, run down to alarm, let alarm time out.
        rep(3, 0, 0, 1, 0);
        rep(1, 1, 0, 0, 0);
        rep(3, 0, 0, 0, 1);
        rep(AT, 0, 0, 0, 1);
        // Second run aborted from alarm.
        rep(1, 1, 0, 0, 0);
        rep(3, 0, 0, 0, 1);
        rep(1, 1, 0, 0, 0);
        // Borrow across digits from 0100, then digit-1 wrap.
        rep(7, 0, 0, 1, 0);
        rep(2, 0, 1, 0, 0);
        rep(1, 0, 0, 1, 0);
        rep(2, 0, 1, 0, 0);
        rep(1, 1, 0, 0, 0);
        rep(1, 0, 0, 0, 1);
        rep(1, 1, 0, 0, 0);
        rep(1, 0, 1, 0, 0);
        rep(1, 0, 1, 0, 0);
        rep(6, 0, 0, 1, 0);
        // Pause at 0042, resume, pause again, abort to SET.
        do_reset();
        rep(2, 0, 0, 1, 0);
        rep(1, 0, 1, 0, 0);
        rep(4, 0, 0, 1, 0);
        rep(3, 0, 1, 0, 0);
        rep(1, 1, 0, 0, 0);
        rep(1, 1, 0, 0, 0);
        rep(5, 0, 0, 0, 1);
        rep(1, 1, 0, 0, 0);
        rep(1, 0, 0, 0, 1);
        rep(1, 1, 0, 0, 0);
        rep(1, 0, 1, 0, 0);
        // Simultaneous TICK+START_STOP at 1 and at 5; CE=0 freezes ticks.
        do_reset();
        rep(1, 0, 0, 1, 0);
        rep(1, 1, 0, 0, 0);
        rep(1, 1, 0, 0, 1);
        rep(1, 1, 0, 0, 0);
        rep(4, 0, 0, 1, 0);
        rep(1, 1, 0, 0, 0);
        rep(1, 1, 0, 0, 1);
        rep(1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1'b0, 1'b0);
        step(1, 0, 0, 0, 1'b0, 1'b0);
        rep(1, 0, 0, 0, 1);
        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) < 4, $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 12,
                 $urandom_range(0, 99) < 35, $urandom_range(0, 99) < 90, $urandom_range(0, 999) < 3);
        end
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (exp_q0.size() == 0 && exp_q1.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL drain: %0d/%0d expected entries left, required 0/0", exp_q0.size(), exp_q1.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
